aes_ct_collector: RTL and testbench

Downstream companion of the byte-serial AES encryption controller. It captures the ciphertext beats that the datapath streams out while the controller's `done` is high and assembles them into a 128-bit block. It presents the block to the host through a valid/ready handshake and tells the input loader, via `full`, when no result slot is free.

---
 rtl/aes_ct_collector_pkg.sv | 13 +
 rtl/aes_ct_collector_if.sv | 21 ++
 rtl/aes_ct_collector_slot_buf.sv | 67 ++++++
 rtl/aes_ct_collector.sv | 64 ++++++
 tb/tb_aes_ct_collector.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/aes_ct_collector_pkg.sv
// aes_ct_pkg: shared widths, collector state type and beat-count helper.
package aes_ct_pkg;

   localparam int AES_BLOCK_W = 128;
   localparam int AES_BEAT_W  = 16;

   typedef enum logic {CT_IDLE, CT_COLLECT} ct_state_e;

   function automatic int beats_f(input int block_w, input int beat_w);
      return block_w / beat_w;
   endfunction

endpackage

// File: rtl/aes_ct_collector_if.sv
// aes_ct_if: beat input, block handshake and status bundle of the ciphertext collector.
interface aes_ct_if
   import aes_ct_pkg::*;
#(
   parameter int BEAT_W  = AES_BEAT_W,
   parameter int BLOCK_W = AES_BLOCK_W
) ();

   logic               done;
   logic [BEAT_W-1:0]  ct_in;
   logic               ct_valid;
   logic [BLOCK_W-1:0] ct_data;
   logic               ct_ready;
   logic               full;
   logic               err;
   logic               err_clr;

   modport master (output done, ct_in, ct_ready, err_clr, input ct_valid, ct_data, full, err);
   modport slave  (input done, ct_in, ct_ready, err_clr, output ct_valid, ct_data, full, err);

endinterface

// File: rtl/aes_ct_collector_slot_buf.sv
// aes_ct_slot_buf: one-entry result slot, or a two-entry in-order FIFO when AES_CT_SKID_EN is defined.
module aes_ct_slot_buf
   import aes_ct_pkg::*;
#(
   parameter int W = AES_BLOCK_W
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         ovf
);

   logic pop;

   assign pop = valid & ready;

`ifdef AES_CT_SKID_EN
   logic         v1;
   logic [W-1:0] d1;

   assign ovf  = push & v1 & ~pop;
   assign full = v1;

   // head/tail entries; on a pop the tail moves to the head and any new block refills behind it
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid <= 1'b0;
         dout  <= '0;
         v1    <= 1'b0;
         d1    <= '0;
      end else if (pop) begin
         valid <= v1 | push;
         dout  <= v1 ? d1 : push ? din : dout;
         v1    <= v1 & push;
         d1    <= (v1 & push) ? din : d1;
      end else if (push && !valid) begin
         valid <= 1'b1;
         dout  <= din;
      end else if (push && !v1) begin
         v1 <= 1'b1;
         d1 <= din;
      end
   end
`else
   assign ovf  = push & valid & ~pop;
   assign full = valid;

   // single slot: a block enters only when the slot is empty or being emptied this cycle
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         valid <= 1'b0;
         dout  <= '0;
      end else if (push && (pop || !valid)) begin
         valid <= 1'b1;
         dout  <= din;
      end else if (pop) begin
         valid <= 1'b0;
      end
   end
`endif

endmodule

// File: rtl/aes_ct_collector.sv
// aes_ct_collector: assembles done-qualified ciphertext beats into blocks; AES_CT_SKID_EN adds a second result slot.
module aes_ct_collector
   import aes_ct_pkg::*;
#(
   parameter int BEAT_W  = AES_BEAT_W,
   parameter int BLOCK_W = AES_BLOCK_W
) (
   input  logic    clk,
   input  logic    rstn,
   aes_ct_if.slave bus
);

   localparam int BEATS = beats_f(BLOCK_W, BEAT_W);
   localparam int CW    = $clog2(BEATS);
   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

   ct_state_e                 state;
   logic [CW-1:0]             bcnt;
   logic [BLOCK_W-BEAT_W-1:0] shreg;
   logic [BLOCK_W-1:0]        nxt;
   logic                      push;
   logic                      trunc;
   logic                      ovf;
   logic                      err_q;

   // shreg only keeps the earlier beats; the final beat joins them on the way into the slot
   assign nxt   = {shreg, bus.ct_in};
   assign push  = state == CT_COLLECT && bus.done && bcnt == LAST;
   assign trunc = state == CT_COLLECT && !bus.done && bcnt != '0;
   assign bus.err = err_q;

   aes_ct_slot_buf #(.W(BLOCK_W)) u_slot (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push),
      .din   (nxt),
      .ready (bus.ct_ready),
      .valid (bus.ct_valid),
      .dout  (bus.ct_data),
      .full  (bus.full),
      .ovf   (ovf)
   );

   // collection FSM, beat counter, shift register and sticky error
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= CT_IDLE;
         bcnt  <= '0;
         shreg <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= (trunc || ovf) ? 1'b1 : bus.err_clr ? 1'b0 : err_q;
         if (bus.done) begin
            shreg <= nxt[BLOCK_W-BEAT_W-1:0];
            bcnt  <= (state == CT_IDLE) ? CW'(1) : (bcnt == LAST) ? '0 : bcnt + 1'b1;
            state <= CT_COLLECT;
         end else begin
            bcnt  <= '0;
            state <= CT_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_aes_ct_collector.sv
// tb_aes_ct_collector: directed and random checks of the collector against a queue-based model; honours AES_CT_SKID_EN.
module tb_aes_ct_collector;
   import aes_ct_pkg::*;

   localparam int BW = 16;
   localparam int KW = 128;
   localparam int NB = KW / BW;
`ifdef AES_CT_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif
   localparam logic [KW-1:0] NOM = 128'h00112233445566778899AABBCCDDEEFF;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   int   checks = 0;
   int   failures = 0;

   logic [BW-1:0] cur[$];
   logic [KW-1:0] outq[$];
   logic          m_err;

   aes_ct_if #(.BEAT_W(BW), .BLOCK_W(KW)) bus ();

   aes_ct_collector #(.BEAT_W(BW), .BLOCK_W(KW)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      cur.delete();
      outq.delete();
      m_err = 1'b0;
   endtask

   // one clock edge of the behaviour: pop, beat capture, block completion, error rules
   task automatic model_edge();
      logic          set;
      logic [KW-1:0] blk;
      set = 1'b0;
      if (outq.size() > 0 && bus.ct_ready) void'(outq.pop_front());
      if (bus.done) cur.push_back(bus.ct_in);
      else if (cur.size() > 0) begin
         set = 1'b1;
         cur.delete();
      end
      if (cur.size() == NB) begin
         blk = '0;
         foreach (cur[i]) blk = {blk[KW-BW-1:0], cur[i]};
         if (outq.size() < CAP) outq.push_back(blk);
         else set = 1'b1;
         cur.delete();
      end
      m_err = set ? 1'b1 : bus.err_clr ? 1'b0 : m_err;
   endtask

   task automatic check_out(input string tag);
      chk({tag, ".ct_valid"}, KW'(bus.ct_valid), KW'(outq.size() > 0));
      if (outq.size() > 0) chk({tag, ".ct_data"}, bus.ct_data, outq[0]);
      chk({tag, ".full"}, KW'(bus.full), KW'(outq.size() == CAP));
      chk({tag, ".err"}, KW'(bus.err), KW'(m_err));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, ".ct_valid"}, KW'(bus.ct_valid), '0);
      chk({tag, ".ct_data"}, bus.ct_data, '0);
      chk({tag, ".full"}, KW'(bus.full), '0);
      chk({tag, ".err"}, KW'(bus.err), '0);
   endtask

   task automatic step(input string tag, input logic d, input logic [BW-1:0] x, input logic r, input logic c);
      bus.done     = d;
      bus.ct_in    = x;
      bus.ct_ready = r;
      bus.err_clr  = c;
      @(posedge clk);
      model_edge();
      #1;
      check_out(tag);
   endtask

   task automatic burst(input string tag, input logic [BW-1:0] x, input logic r);
      for (int i = 0; i < NB; i++) step(tag, 1'b1, x, r, 1'b0);
   endtask

   initial begin
      bus.done = 1'b0;
      bus.ct_in = '0;
      bus.ct_ready = 1'b0;
      bus.err_clr = 1'b0;
      model_reset();
      repeat (5) begin
         @(posedge clk);
         #1;
         bus.done = 1'($urandom);
         bus.ct_in = BW'($urandom);
         bus.ct_ready = 1'($urandom);
         bus.err_clr = 1'($urandom);
      end
      check_zero("reset");
      bus.done = 1'b0;
      bus.ct_ready = 1'b0;
      bus.err_clr = 1'b0;
      rstn = 1'b1;

      for (int i = 0; i < NB; i++)
         step("nominal", 1'b1, {4'(2*i), 4'(2*i), 4'(2*i+1), 4'(2*i+1)}, 1'b0, 1'b0);
      chk("nominal.block", bus.ct_data, NOM);
      step("nominal.pop", 1'b0, '0, 1'b1, 1'b0);
      chk("nominal.popped", KW'(bus.ct_valid), '0);

      for (int i = 0; i < NB; i++)
         step("bp", 1'b1, {4'(2*i), 4'(2*i), 4'(2*i+1), 4'(2*i+1)}, 1'b0, 1'b0);
      repeat (20) step("bp.hold", 1'b0, BW'($urandom), 1'b0, 1'b0);
      chk("bp.data", bus.ct_data, NOM);
      chk("bp.full", KW'(bus.full), KW'(CAP == 1));

      burst("ovr", 16'hA5A5, 1'b0);
      step("ovr.idle", 1'b0, '0, 1'b0, 1'b0);
      chk("ovr.data", bus.ct_data, NOM);
`ifdef AES_CT_SKID_EN
      chk("ovr.full", KW'(bus.full), KW'(1));
      chk("ovr.err", KW'(bus.err), '0);
      step("ovr.pop1", 1'b0, '0, 1'b1, 1'b0);
      chk("ovr.second", bus.ct_data, {NB{16'hA5A5}});
`else
      chk("ovr.err", KW'(bus.err), KW'(1));
      step("ovr.pop1", 1'b0, '0, 1'b1, 1'b0);
`endif
      step("ovr.pop2", 1'b0, '0, 1'b1, 1'b0);
      step("ovr.clr", 1'b0, '0, 1'b0, 1'b1);
      chk("ovr.cleared", KW'(bus.err), '0);

      for (int i = 0; i < 5; i++) step("trunc", 1'b1, BW'($urandom), 1'b1, 1'b0);
      step("trunc.end", 1'b0, '0, 1'b1, 1'b0);
      chk("trunc.err", KW'(bus.err), KW'(1));
      chk("trunc.novalid", KW'(bus.ct_valid), '0);
      step("trunc.clr", 1'b0, '0, 1'b0, 1'b1);
      burst("trunc.after", BW'($urandom), 1'b0);
      step("trunc.pop", 1'b0, '0, 1'b1, 1'b0);

      for (int i = 0; i < 3; i++) step("midrst", 1'b1, BW'($urandom), 1'b0, 1'b0);
      bus.done = 1'b0;
      #2 rstn = 1'b0;
      #1 check_zero("midrst.zero");
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
      burst("midrst.after", 16'h1234, 1'b0);
      chk("midrst.block", bus.ct_data, {NB{16'h1234}});
      chk("midrst.err", KW'(bus.err), '0);
      step("midrst.pop", 1'b0, '0, 1'b1, 1'b0);

      for (int n = 0; n < 3000; n++)
         step("rand", $urandom_range(0, 9) != 0, BW'($urandom), 1'($urandom), $urandom_range(0, 15) == 0);
      repeat (4) step("drain", 1'b0, '0, 1'b1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
